multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle successor to the single-cycle decoder: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB per instruction.
//  Sits between instruction register (opcode) and datapath; stalls on memory via mem_ready; counts retired instructions.
// PARAMETERS
//  OPCODE_W  4   opcode width; bits above [3:0] must be 0, else opcode is illegal
//  CNT_W     16  retired-instruction counter width
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  opcode       in   OPCODE_W from IR; stable from DECODE until instr_done
//  mem_ready    in   1        memory completes access this cycle
//  zero         in   1        ALU zero flag, sampled in EXEC
//  pc_write     out  1        load PC
//  pc_src       out  1        0 = PC+4, 1 = branch target
//  ir_write     out  1        load IR
//  reg_dst      out  1        rd (1) vs rt (0) write address
//  alu_src      out  1        1 = sign-extended immediate
//  alu_op       out  3        000 add, 001 sub, 010 and, 011 or, 100 nor, 111 use funct
//  mem_read     out  1        memory read strobe
//  mem_write    out  1        memory write strobe
//  mem_to_reg   out  1        writeback from memory data
//  reg_write    out  1        register file write enable
//  slti         out  1        writeback sign bit of sub result (set-less-than)
//  state        out  3        FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//  instr_done   out  1        one-cycle pulse on retire
//  instr_count  out  CNT_W    retired instructions, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Opcodes: 0 R-type, 1 addi, 2 andi, 3 ori, 4 nori, 5 beq, 6 bne, 7 slti, 8 lw, 9 sw; 10-15 illegal.
//  Outputs decoded combinationally from state+opcode+zero+mem_ready; any output not listed for a state is 0.
//  rst high: state=FETCH, instr_count=0, ALL outputs forced 0 (incl. mem_read) while rst held; mid-instruction
//   reset abandons pending memory access; first FETCH strobes on cycle after rst deasserts.
//  FETCH: mem_read=1; ir_write=pc_write=mem_ready, pc_src=0; stay while !mem_ready, else -> DECODE.
//  DECODE: no strobes; legal -> EXEC, illegal -> see CONFIGURATION.
//  EXEC: alu_op: R 111; addi/lw/sw 000; beq/bne/slti 001; andi 010; ori 011; nori 100.
//   alu_src=1 for addi/andi/ori/nori/slti/lw/sw; reg_dst=1 for R.
//   beq: pc_write=zero; bne: pc_write=!zero; pc_src=1; instr_done=1 -> FETCH.
//   lw/sw -> MEM; all others -> WB.
//  MEM: mem_read=1 (lw) or mem_write=1 (sw) held until mem_ready; sw+mem_ready: instr_done=1 -> FETCH;
//   lw+mem_ready -> WB.
//  WB: reg_write=1; reg_dst=1 (R); mem_to_reg=1 (lw); slti=1 (slti); instr_done=1 -> FETCH.
//  Latency with mem_ready=1: branch 3, R/imm/slti/sw 4, lw 5 cycles; each mem_ready=0 cycle adds 1.
//  instr_count += 1 on clock edge where instr_done=1; wrap silently.
//  mem_read and mem_write never asserted together; pc_write never in DECODE/WB.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> TRAP; TRAP holds all strobes 0, state=5, no retire,
//   exits only by rst.
//  Undefined: illegal opcode treated as NOP: DECODE asserts instr_done=1 (counted) -> FETCH; TRAP unreachable.
// TESTING
//  rst pulse mid-MEM of lw -> state=0, all outputs 0 during rst, instr_count=0, FETCH mem_read=1 next cycle.
//  R-type (0000), mem_ready=1 -> states 0,1,2,4; alu_op=111 in EXEC; reg_write=reg_dst=1 in WB; count +1.
//  lw (1000), mem_ready low 2 cycles in MEM -> 7 cycles total; mem_to_reg=reg_write=1 in WB.
//  beq zero=1 -> pc_write=pc_src=1 in EXEC, retire in 3 cycles; bne zero=1 -> pc_write=0, still retires.
//  sw (1001) -> mem_write=1 only in MEM, no reg_write; CNT_W=2 after 4 retires -> instr_count=0.
//  opcode 1111: with ILLEGAL_TRAP_EN -> state=5 held, count frozen; without -> instr_done in DECODE, back to 0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction-register/datapath side (master) and control unit (slave).
interface multicycle_control_unit_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                zero;
  logic                pc_write;
  logic                pc_src;
  logic                ir_write;
  logic                reg_dst;
  logic                alu_src;
  logic [2:0]          alu_op;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                reg_write;
  logic                slti;
  logic [2:0]          state;
  logic                instr_done;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    output opcode, mem_ready, zero,
    input  pc_write, pc_src, ir_write, reg_dst, alu_src, alu_op, mem_read, mem_write,
           mem_to_reg, reg_write, slti, state, instr_done, instr_count
  );

  modport slave (
    input  opcode, mem_ready, zero,
    output pc_write, pc_src, ir_write, reg_dst, alu_src, alu_op, mem_read, mem_write,
           mem_to_reg, reg_write, slti, state, instr_done, instr_count
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB with a retired-instruction counter.
// ILLEGAL_TRAP_EN: illegal opcodes lock into TRAP; otherwise they retire as NOPs in DECODE.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned CNT_W    = 16
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_control_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    OP_R    = 4'd0,
    OP_ADDI = 4'd1,
    OP_ANDI = 4'd2,
    OP_ORI  = 4'd3,
    OP_NORI = 4'd4,
    OP_BEQ  = 4'd5,
    OP_BNE  = 4'd6,
    OP_SLTI = 4'd7,
    OP_LW   = 4'd8,
    OP_SW   = 4'd9,
    OP_ILL  = 4'd15
  } op_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  op_e              op;
  logic             illegal;

  logic       pc_write_c, pc_src_c, ir_write_c, reg_dst_c, alu_src_c;
  logic [2:0] alu_op_c;
  logic       mem_read_c, mem_write_c, mem_to_reg_c, reg_write_c, slti_c, done_c;

  // Any value above 9 is illegal, which also covers set bits above [3:0].
  always_comb begin
    illegal = (bus.opcode > OPCODE_W'(9));
    op      = illegal ? OP_ILL : op_e'(bus.opcode[3:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (done_c) count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_write_c   = 1'b0;
    pc_src_c     = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = 3'b000;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    slti_c       = 1'b0;
    done_c       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        ir_write_c = bus.mem_ready;
        pc_write_c = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          done_c  = 1'b1;
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        reg_dst_c = (op == OP_R);
        unique case (op)
          OP_R:                      alu_op_c = 3'b111;
          OP_ANDI:                   alu_op_c = 3'b010;
          OP_ORI:                    alu_op_c = 3'b011;
          OP_NORI:                   alu_op_c = 3'b100;
          OP_BEQ, OP_BNE, OP_SLTI:   alu_op_c = 3'b001;
          default:                   alu_op_c = 3'b000;
        endcase
        alu_src_c = (op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_NORI, OP_SLTI, OP_LW, OP_SW});
        if (op == OP_BEQ || op == OP_BNE) begin
          pc_write_c = (op == OP_BEQ) ? bus.zero : !bus.zero;
          pc_src_c   = 1'b1;
          done_c     = 1'b1;
          state_d    = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (op == OP_LW) begin
          mem_read_c = 1'b1;
          if (bus.mem_ready) state_d = S_WB;
        end else if (op == OP_SW) begin
          mem_write_c = 1'b1;
          if (bus.mem_ready) begin
            done_c  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = (op == OP_R);
        mem_to_reg_c = (op == OP_LW);
        slti_c       = (op == OP_SLTI);
        done_c       = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every strobe, so an in-flight memory access is dropped immediately.
  always_comb begin
    bus.pc_write    = !rst && pc_write_c;
    bus.pc_src      = !rst && pc_src_c;
    bus.ir_write    = !rst && ir_write_c;
    bus.reg_dst     = !rst && reg_dst_c;
    bus.alu_src     = !rst && alu_src_c;
    bus.alu_op      = rst ? '0 : alu_op_c;
    bus.mem_read    = !rst && mem_read_c;
    bus.mem_write   = !rst && mem_write_c;
    bus.mem_to_reg  = !rst && mem_to_reg_c;
    bus.reg_write   = !rst && reg_write_c;
    bus.slti        = !rst && slti_c;
    bus.instr_done  = !rst && done_c;
    bus.state       = state_q;
    bus.instr_count = count_q;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected cycle plans built from the ISA rules.
module tb_multicycle_control_unit;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(4), .CNT_W(CW)) bus ();
  multicycle_control_unit #(.OPCODE_W(4), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int fails  = 0;
  logic [CW-1:0] exp_cnt;
  logic [16:0] plan_exp[$];
  bit          plan_mr[$];
  bit          plan_z[$];
  int lat;
  bit seen;
  int z_sel = -1;

  function automatic logic [16:0] rec(int st, bit pcw, bit pcs, bit irw, bit rd, bit as, int aop,
                                      bit mrd, bit mwr, bit m2r, bit rw, bit sl, bit dn);
    return {3'(st), pcw, pcs, irw, rd, as, 3'(aop), mrd, mwr, m2r, rw, sl, dn};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.state, bus.pc_write, bus.pc_src, bus.ir_write, bus.reg_dst, bus.alu_src, bus.alu_op,
            bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_write, bus.slti, bus.instr_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit pick_z();
    return (z_sel < 0) ? bit'($urandom_range(0, 1)) : bit'(z_sel);
  endfunction

  task automatic push(input logic [16:0] e, input bit mr, input bit z);
    plan_exp.push_back(e);
    plan_mr.push_back(mr);
    plan_z.push_back(z);
  endtask

  // Expected per-cycle outputs of one instruction, given fetch/mem wait counts.
  task automatic build_plan(input int op, input int nf, input int nm);
    int aop;
    bit as, rd, z, br, mm;
    plan_exp.delete(); plan_mr.delete(); plan_z.delete();
    for (int i = 0; i < nf; i++) push(rec(0,0,0,0,0,0,0,1,0,0,0,0,0), 0, pick_z());
    push(rec(0,1,0,1,0,0,0,1,0,0,0,0,0), 1, pick_z());
    if (op > 9) begin
      push(rec(1,0,0,0,0,0,0,0,0,0,0,0,1), bit'($urandom_range(0, 1)), pick_z());
      return;
    end
    push(rec(1,0,0,0,0,0,0,0,0,0,0,0,0), bit'($urandom_range(0, 1)), pick_z());
    case (op)
      0: aop = 7;
      2: aop = 2;
      3: aop = 3;
      4: aop = 4;
      5, 6, 7: aop = 1;
      default: aop = 0;
    endcase
    as = (op >= 1 && op <= 4) || op >= 7;
    rd = (op == 0);
    br = (op == 5 || op == 6);
    mm = (op == 8 || op == 9);
    z  = pick_z();
    if (br) begin
      push(rec(2, (op == 5) ? z : !z, 1, 0, 0, 1'b0, aop, 0,0,0,0,0,1), bit'($urandom_range(0, 1)), z);
      return;
    end
    push(rec(2,0,0,0,rd,as,aop,0,0,0,0,0,0), bit'($urandom_range(0, 1)), z);
    if (mm) begin
      for (int i = 0; i < nm; i++) push(rec(3,0,0,0,0,0,0, op == 8, op == 9, 0,0,0,0), 0, pick_z());
      push(rec(3,0,0,0,0,0,0, op == 8, op == 9, 0,0,0, op == 9), 1, pick_z());
      if (op == 9) return;
    end
    push(rec(4,0,0,0,rd,0,0,0,0, op == 8, 1, op == 7, 1), bit'($urandom_range(0, 1)), pick_z());
  endtask

  task automatic step_plan(input int n);
    logic [16:0] e;
    for (int i = 0; i < n && plan_exp.size() > 0; i++) begin
      e = plan_exp.pop_front();
      bus.mem_ready = plan_mr.pop_front();
      bus.zero      = plan_z.pop_front();
      @(negedge clk);
      check($sformatf("ctl op=%0d", bus.opcode), 32'(observed()), 32'(e));
      check("count", 32'(bus.instr_count), 32'(exp_cnt));
      if (!seen) lat++;
      if (bus.instr_done) seen = 1;
      if (e[0]) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input int op, input int nf, input int nm);
    bus.opcode = 4'(op);
    build_plan(op, nf, nm);
    lat  = 0;
    seen = 0;
    step_plan(plan_exp.size());
  endtask

  initial begin
    rst = 1'b1;
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    check("reset_outputs", 32'(observed()), 32'd0);
    check("reset_count", 32'(bus.instr_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(0, 0, 0);  check("lat_r", 32'(lat), 32'd4);
    run_instr(8, 0, 2);  check("lat_lw_stall2", 32'(lat), 32'd7);
    z_sel = 1;
    run_instr(5, 0, 0);  check("lat_beq", 32'(lat), 32'd3);
    run_instr(6, 0, 0);  check("lat_bne", 32'(lat), 32'd3);
    z_sel = -1;
    check("wrap_after_4", 32'(bus.instr_count), 32'd0);
    run_instr(9, 0, 0);  check("lat_sw", 32'(lat), 32'd4);
    run_instr(7, 1, 0);  check("lat_slti_fstall", 32'(lat), 32'd5);

    // Reset in the middle of a stalled lw memory access.
    bus.opcode = 4'd8;
    build_plan(8, 0, 3);
    step_plan(4);
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", 32'(observed()), 32'd0);
    check("rst_async_count", 32'(bus.instr_count), 32'd0);
    exp_cnt = '0;
    @(posedge clk); #1;
    check("rst_held_outputs", 32'(observed()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("fetch_after_rst", 32'(observed()), 32'(rec(0,0,0,0,0,0,0,1,0,0,0,0,0)));
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
`ifdef ILLEGAL_TRAP_EN
      run_instr($urandom_range(0, 9), $urandom_range(0, 2), $urandom_range(0, 2));
`else
      run_instr($urandom_range(0, 15), $urandom_range(0, 2), $urandom_range(0, 2));
`endif
    end

`ifdef ILLEGAL_TRAP_EN
    bus.opcode = 4'd15;
    build_plan(15, 0, 0);
    lat = 0; seen = 0;
    step_plan(1);
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = bit'($urandom_range(0, 1));
      @(negedge clk);
      check("trap_hold", 32'(observed()), 32'(rec(5,0,0,0,0,0,0,0,0,0,0,0,0)));
      check("trap_count", 32'(bus.instr_count), 32'(exp_cnt));
      @(posedge clk); #1;
    end
`else
    run_instr(15, 0, 0); check("lat_illegal_nop", 32'(lat), 32'd2);
    run_instr(1, 0, 0);  check("lat_after_nop", 32'(lat), 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
